// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch unit. Issues single-outstanding word reads to instruction
//   memory over a req/ack handshake, buffers returned words in a 2-entry queue
//   and presents the queue head to the decoder. Supports decoder back-pressure
//   (I_stall) and single-cycle branch redirects from execute (I_branch).
//
// Parameters
//   RESET_PC    : fetch address loaded at reset
//   PC_INC      : address increment per instruction (word-addressed memory)
//
// Ports
//   I_clk       : clock, rising edge
//   I_rstn      : synchronous active-low reset
//   I_run       : fetch enable; no new requests are raised while low
//   I_stall     : decoder cannot accept; head outputs hold
//   I_branch    : redirect strobe (priority over stall, push and pop)
//   I_branch_pc : redirect target, sampled with I_branch
//   O_mem_req   : memory read request
//   O_mem_addr  : request address, stable while O_mem_req is high
//   I_mem_ack   : read data valid, honoured only while O_mem_req is high
//   I_mem_data  : read data, sampled on an ack edge
//   O_inst      : queue-head instruction
//   O_en        : queue non-empty
//   O_pc        : address of O_inst
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd1
) (
    input  logic        I_clk,
    input  logic        I_rstn,
    input  logic        I_run,
    input  logic        I_stall,
    input  logic        I_branch,
    input  logic [15:0] I_branch_pc,
    output logic        O_mem_req,
    output logic [15:0] O_mem_addr,
    input  logic        I_mem_ack,
    input  logic [15:0] I_mem_data,
    output logic [15:0] O_inst,
    output logic        O_en,
    output logic [15:0] O_pc
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        mem_req_s;
    logic        raise_s;

    logic [15:0] next_pc_r;
    logic [15:0] next_pc_next_s;
    logic [15:0] mem_addr_r;
    logic [15:0] mem_addr_next_s;
    logic [15:0] pc_src_s;
    logic        drop_r;
    logic        drop_next_s;

    // Queue: head is always the oldest entry, tail the younger one.
    logic [15:0] head_inst_r;
    logic [15:0] head_pc_r;
    logic [15:0] tail_inst_r;
    logic [15:0] tail_pc_r;
    logic [15:0] head_inst_next_s;
    logic [15:0] head_pc_next_s;
    logic [15:0] tail_inst_next_s;
    logic [15:0] tail_pc_next_s;
    logic [1:0]  count_r;
    logic [1:0]  count_mid_s;
    logic [1:0]  count_next_s;
    logic        en_r;

    logic        ack_s;
    logic        push_s;
    logic        pop_s;
    logic        issue_s;

    // Handshake qualifiers: an ack only counts while a request is up, and a
    // branch both blocks the push of returning data and the decoder pop.
    always_comb begin
        ack_s   = mem_req_s & I_mem_ack;
        push_s  = ack_s & ~drop_r & ~I_branch;
        pop_s   = (count_r != 2'd0) & ~I_stall & ~I_branch;
        issue_s = I_run & (count_next_s <= 2'd1);
    end

    // Queue next-state: pop shifts tail into head, then a push lands behind
    // whatever remains; a branch flushes everything.
    always_comb begin
        head_inst_next_s = head_inst_r;
        head_pc_next_s   = head_pc_r;
        tail_inst_next_s = tail_inst_r;
        tail_pc_next_s   = tail_pc_r;
        count_mid_s      = count_r;
        count_next_s     = count_r;
        if (I_branch) begin
            count_next_s = 2'd0;
        end else begin
            if (pop_s) begin
                head_inst_next_s = tail_inst_r;
                head_pc_next_s   = tail_pc_r;
                count_mid_s      = count_r - 2'd1;
            end else begin
                count_mid_s = count_r;
            end
            if (push_s) begin
                case (count_mid_s)
                    2'd0: begin
                        head_inst_next_s = I_mem_data;
                        head_pc_next_s   = mem_addr_r;
                        count_next_s     = 2'd1;
                    end
                    2'd1: begin
                        tail_inst_next_s = I_mem_data;
                        tail_pc_next_s   = mem_addr_r;
                        count_next_s     = 2'd2;
                    end
                    // A request is only raised with room for its data, so a
                    // push into a full queue cannot happen; hold the count.
                    default: begin
                        count_next_s = count_mid_s;
                    end
                endcase
            end else begin
                count_next_s = count_mid_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge I_clk) begin
        if (!I_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: a request stays up until acked; on completion (or when
    // idle) a new one is raised if the queue will have room for its data.
    always_comb begin
        state_next_s = state_r;
        raise_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_next_s = ST_BUSY;
                    raise_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ack_s && issue_s) begin
                    state_next_s = ST_BUSY;
                    raise_s      = 1'b1;
                end else if (ack_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: the request line is a pure decode of the state register.
    always_comb begin
        case (state_r)
            ST_BUSY: mem_req_s = 1'b1;
            ST_IDLE: mem_req_s = 1'b0;
            default: mem_req_s = 1'b0;
        endcase
    end

    // Address path: a branch redirects the fetch stream immediately, so a
    // request raised on the branch edge already targets I_branch_pc.
    always_comb begin
        pc_src_s = I_branch ? I_branch_pc : next_pc_r;
        if (raise_s) begin
            mem_addr_next_s = pc_src_s;
            next_pc_next_s  = pc_src_s + PC_INC;
        end else begin
            mem_addr_next_s = mem_addr_r;
            next_pc_next_s  = pc_src_s;
        end
    end

    // Drop flag: a branch during an unacked request marks its data stale;
    // the ack that completes that request clears it.
    always_comb begin
        if (ack_s) begin
            drop_next_s = 1'b0;
        end else if (I_branch && mem_req_s) begin
            drop_next_s = 1'b1;
        end else begin
            drop_next_s = drop_r;
        end
    end

    // Datapath registers: addresses, drop flag and queue storage.
    always_ff @(posedge I_clk) begin
        if (!I_rstn) begin
            next_pc_r   <= RESET_PC;
            mem_addr_r  <= RESET_PC;
            drop_r      <= 1'b0;
            head_inst_r <= 16'h0000;
            head_pc_r   <= RESET_PC;
            tail_inst_r <= 16'h0000;
            tail_pc_r   <= RESET_PC;
            count_r     <= 2'd0;
            en_r        <= 1'b0;
        end else begin
            next_pc_r   <= next_pc_next_s;
            mem_addr_r  <= mem_addr_next_s;
            drop_r      <= drop_next_s;
            head_inst_r <= head_inst_next_s;
            head_pc_r   <= head_pc_next_s;
            tail_inst_r <= tail_inst_next_s;
            tail_pc_r   <= tail_pc_next_s;
            count_r     <= count_next_s;
            en_r        <= (count_next_s != 2'd0);
        end
    end

    assign O_mem_req  = mem_req_s;
    assign O_mem_addr = mem_addr_r;
    assign O_inst     = head_inst_r;
    assign O_pc       = head_pc_r;
    assign O_en       = en_r;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Self-checking bench for inst_fetch. Two instances share all control
//   inputs: dut0 starts at 16'h0000, dut1 at 16'hFFFE (address wrap).
//   The memory returns addr ^ 16'h1700 with a programmable wait count.
//   Directed steps check cycle timing; a randomized phase checks that the
//   instructions accepted by the decoder form the program-order stream
//   (consecutive addresses, restarted at each branch target).
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        run;
    logic        stall;
    logic        branch;
    logic [15:0] bpc;
    logic        ack;
    logic [15:0] data0;
    logic [15:0] data1;

    logic        req0;
    logic [15:0] addr0;
    logic [15:0] inst0;
    logic        en0;
    logic [15:0] pc0;
    logic        req1;
    logic [15:0] addr1;
    logic [15:0] inst1;
    logic        en1;
    logic [15:0] pc1;

    int          n_tests = 0;
    int          n_fail  = 0;

    int          mem_wait;
    int          waited;
    bit          rand_wait;
    bit          force_ack;
    logic        prev_req;
    logic        prev_ack;
    logic [15:0] prev_addr;

    logic [15:0] exp0;
    logic [15:0] exp1;
    int          acc;
    bit          found;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return a ^ 16'h1700;
    endfunction

    assign data0 = mem_fn(addr0);
    assign data1 = mem_fn(addr1);

    inst_fetch #(.RESET_PC(16'h0000), .PC_INC(16'd1)) dut0 (
        .I_clk(clk), .I_rstn(rstn), .I_run(run), .I_stall(stall),
        .I_branch(branch), .I_branch_pc(bpc),
        .O_mem_req(req0), .O_mem_addr(addr0), .I_mem_ack(ack), .I_mem_data(data0),
        .O_inst(inst0), .O_en(en0), .O_pc(pc0)
    );

    inst_fetch #(.RESET_PC(16'hFFFE), .PC_INC(16'd1)) dut1 (
        .I_clk(clk), .I_rstn(rstn), .I_run(run), .I_stall(stall),
        .I_branch(branch), .I_branch_pc(bpc),
        .O_mem_req(req1), .O_mem_addr(addr1), .I_mem_ack(ack), .I_mem_data(data1),
        .O_inst(inst1), .O_en(en1), .O_pc(pc1)
    );

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    // Memory responder: acks after mem_wait idle cycles of a request and
    // checks that the address holds while a request waits.
    always @(negedge clk) begin
        if (req0 === 1'b1 && prev_req === 1'b1 && prev_ack === 1'b0) begin
            chk16("addr_hold", addr0, prev_addr);
        end
        if (req0 === 1'b1 && waited >= mem_wait) begin
            ack    = 1'b1;
            waited = 0;
            if (rand_wait) mem_wait = $urandom_range(0, 3);
        end else begin
            ack = force_ack;
            if (req0 === 1'b1) waited = waited + 1;
            else               waited = 0;
        end
        prev_req  = req0;
        prev_ack  = ack;
        prev_addr = addr0;
    end

    task automatic do_reset(input int w);
        rstn      = 1'b0;
        run       = 1'b0;
        stall     = 1'b0;
        branch    = 1'b0;
        bpc       = 16'h0000;
        force_ack = 1'b0;
        rand_wait = 1'b0;
        mem_wait  = w;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        waited    = 0;
        ack       = 1'b0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = 16'h0000;

        // Reset state and zero-wait stream (both instances, dut1 wraps).
        do_reset(0);
        chk1 ("rst_req",   req0,  1'b0);
        chk1 ("rst_en",    en0,   1'b0);
        chk16("rst_inst",  inst0, 16'h0000);
        chk16("rst_pc",    pc0,   16'h0000);
        chk16("rst_addr",  addr0, 16'h0000);
        chk16("rst_pc1",   pc1,   16'hFFFE);
        chk16("rst_addr1", addr1, 16'hFFFE);
        rstn = 1'b1;
        run  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk1 ("strm_req",  req0, 1'b1);
            chk1 ("strm_req1", req1, 1'b1);
            chk16("strm_addr", addr0, 16'(c - 1));
            chk1 ("strm_en",   en0, (c >= 2));
            if (c >= 2) begin
                chk16("strm_pc",    pc0,   16'(c - 2));
                chk16("strm_inst",  inst0, mem_fn(16'(c - 2)));
                chk16("wrap_pc",    pc1,   16'hFFFE + 16'(c - 2));
                chk16("wrap_inst",  inst1, mem_fn(16'hFFFE + 16'(c - 2)));
            end
            if (c == 8) stall = 1'b1;
        end

        // Stall for 5 cycles: head holds, requests stop, nothing lost.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1 ("stall_en",   en0,   1'b1);
            chk16("stall_pc",   pc0,   16'd6);
            chk16("stall_inst", inst0, mem_fn(16'd6));
            chk1 ("stall_req",  req0,  1'b0);
            if (i == 4) stall = 1'b0;
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk1 ("rel_en",   en0,   1'b1);
            chk16("rel_pc",   pc0,   16'(7 + j));
            chk16("rel_inst", inst0, mem_fn(16'(7 + j)));
            if (j == 0) chk16("rel_addr", addr0, 16'd8);
        end

        // Three wait states per request, then branch while one is pending.
        do_reset(3);
        rstn = 1'b1;
        run  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk1 ("ws_req",  req0,  1'b1);
            chk16("ws_addr", addr0, 16'((c - 1) / 4));
            chk1 ("ws_en",   en0,   (c >= 5) && ((c - 5) % 4 == 0));
            if ((c >= 5) && ((c - 5) % 4 == 0)) begin
                chk16("ws_pc",   pc0,   16'((c - 5) / 4));
                chk16("ws_inst", inst0, mem_fn(16'((c - 5) / 4)));
            end
            if (c == 10) begin
                branch = 1'b1;
                bpc    = 16'h0040;
            end
        end
        @(negedge clk);
        branch = 1'b0;
        chk1 ("brw_en",   en0,   1'b0);
        chk1 ("brw_req",  req0,  1'b1);
        chk16("brw_addr", addr0, 16'd2);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (en0) found = 1'b1;
        end
        chk1("brw_found", found, 1'b1);
        if (found) begin
            chk16("brw_pc",   pc0,   16'h0040);
            chk16("brw_inst", inst0, mem_fn(16'h0040));
        end

        // Branch coincident with stall and ack.
        do_reset(0);
        rstn = 1'b1;
        run  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c >= 2) chk16("bsa_pre_pc", pc0, 16'(c - 2));
            if (c == 4) begin
                stall  = 1'b1;
                branch = 1'b1;
                bpc    = 16'h0123;
            end
        end
        @(negedge clk);
        stall  = 1'b0;
        branch = 1'b0;
        chk1 ("bsa_en0",  en0,   1'b0);
        chk1 ("bsa_req",  req0,  1'b1);
        chk16("bsa_addr", addr0, 16'h0123);
        @(negedge clk);
        chk1 ("bsa_en1",  en0,   1'b1);
        chk16("bsa_pc",   pc0,   16'h0123);
        chk16("bsa_inst", inst0, mem_fn(16'h0123));
        @(negedge clk);
        chk16("bsa_pc2",  pc0,   16'h0124);

        // Reset in the middle of a request, then a late ack.
        do_reset(3);
        rstn = 1'b1;
        run  = 1'b1;
        @(negedge clk);
        chk1 ("rmr_req1",  req0,  1'b1);
        chk16("rmr_addr1", addr0, 16'h0000);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk1 ("rmr_req2",  req0,  1'b0);
        chk1 ("rmr_en2",   en0,   1'b0);
        chk16("rmr_addr2", addr0, 16'h0000);
        force_ack = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        run  = 1'b0;
        @(negedge clk);
        chk1("rmr_req3", req0, 1'b0);
        chk1("rmr_en3",  en0,  1'b0);
        force_ack = 1'b0;
        run       = 1'b1;
        @(negedge clk);
        chk1 ("rmr_req4",  req0,  1'b1);
        chk16("rmr_addr4", addr0, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (en0) found = 1'b1;
        end
        chk1("rmr_found", found, 1'b1);
        if (found) begin
            chk16("rmr_pc",   pc0,   16'h0000);
            chk16("rmr_inst", inst0, mem_fn(16'h0000));
        end

        // Randomized traffic against the program-order stream model.
        do_reset(0);
        rand_wait = 1'b1;
        rstn      = 1'b1;
        run       = 1'b1;
        exp0      = 16'h0000;
        exp1      = 16'hFFFE;
        acc       = 0;
        for (int cy = 0; cy < 3000; cy++) begin
            @(negedge clk);
            run    = ($urandom_range(0, 9) != 0);
            stall  = ($urandom_range(0, 3) == 0);
            branch = ($urandom_range(0, 24) == 0);
            bpc    = 16'($urandom);
            if (en0 && !stall && !branch) begin
                chk16("sb_pc0",   pc0,   exp0);
                chk16("sb_inst0", inst0, mem_fn(exp0));
                exp0 = exp0 + 16'd1;
                acc++;
            end
            if (en1 && !stall && !branch) begin
                chk16("sb_pc1",   pc1,   exp1);
                chk16("sb_inst1", inst1, mem_fn(exp1));
                exp1 = exp1 + 16'd1;
            end
            if (branch) begin
                exp0 = bpc;
                exp1 = bpc;
            end
        end
        rand_wait = 1'b0;
        stall     = 1'b0;
        branch    = 1'b0;
        chk1("sb_progress", (acc > 100), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
